dmem_arbiter: RTL

Shares the single data-memory port between the pipeline MEM stage (core) and a debug/loader port (dbg). Sequences each access as a multi-cycle transaction with a configurable read latency. Stalls the pipeline while a core access is pending. Core has fixed priority, with a starvation guard for dbg. Sits between the EX/MEM register outputs and datamemory.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares the data-memory port between the MEM stage and a
//                debug/loader port with fixed core priority and dbg starvation guard.
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic                  core_stall,
    output logic                  core_done,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_done,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_dbg;
    logic        txn_we;
    logic [2:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        starved;
    logic        grant_core;
    logic        grant_dbg;

    assign starved = (starve_cnt >= 4'(STARVE_MAX));

    always_comb begin
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        state_nxt  = state;
        case (state)
            ST_IDLE: begin
                if (dbg_req && starved) begin
                    grant_dbg = 1'b1;
                end else if (core_req) begin
                    grant_core = 1'b1;
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                end
                if (grant_core || grant_dbg) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD:  state_nxt = txn_we ? ST_DONE : ST_WAIT;
            ST_WAIT: if (wait_cnt == 3'd1) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_dbg  <= 1'b0;
            txn_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_func3  <= 3'b000;
            wait_cnt   <= 3'd0;
            core_rdata <= '0;
            dbg_rdata  <= '0;
        end else begin
            if (grant_core || grant_dbg) begin
                owner_dbg <= grant_dbg;
                txn_we    <= grant_dbg ? dbg_we    : core_we;
                mem_addr  <= grant_dbg ? dbg_addr  : core_addr;
                mem_wdata <= grant_dbg ? dbg_wdata : core_wdata;
                mem_func3 <= grant_dbg ? 3'b010    : core_func3;
            end
            if (state == ST_CMD) begin
                wait_cnt <= 3'(MEM_LAT);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
                // Last wait cycle: memory data is valid MEM_LAT cycles after the strobe.
                if (wait_cnt == 3'd1) begin
                    if (owner_dbg) begin
                        dbg_rdata <= mem_rdata;
                    end else begin
                        core_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // Counts cycles dbg is kept waiting; frozen while dbg owns the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant_dbg) begin
            starve_cnt <= 4'd0;
        end else if (dbg_req && !(owner_dbg && state != ST_IDLE) && starve_cnt != 4'd15) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign mem_re     = (state == ST_CMD) && !txn_we;
    assign mem_we     = (state == ST_CMD) &&  txn_we;
    assign core_done  = (state == ST_DONE) && !owner_dbg;
    assign dbg_done   = (state == ST_DONE) &&  owner_dbg;
    assign core_stall = core_req && !core_done;

endmodule
`default_nettype wire
